bcd_countdown_timer: RTL
========================

# bcd_countdown_timer

Parametrised multi-digit BCD count-down timer for game-time and round-time tracking in the whack-a-mole datapath. Counts a loadable BCD value down by one every CYCLES_PER_STEP clocks. Adds start/pause control, saturating BCD time-bonus addition, a one-cycle expiry pulse and a step strobe for display and scoring logic. Sits between the game controller, which loads, starts and adds bonus time, and the seven-segment display driver.

## Interface
- NUM_DIGITS, 2, number of BCD digits (1..8); value width W = 4*NUM_DIGITS
- CYCLES_PER_STEP, 50000000, clocks per decrement (>=2); prescaler width = clog2(CYCLES_PER_STEP)
- RESET_VALUE, 'h60, BCD value loaded by reset (W bits)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- load  in  1  load load_value, go to IDLE
- load_value  in  W  BCD value to load
- start  in  1  begin/resume counting
- pause  in  1  suspend counting
- add_en  in  1  add add_value to current value (bonus time)
- add_value  in  W  BCD increment
- digits  out  W  current BCD value, digit 0 = bits [3:0] (ones)
- running  out  1  high while state == RUN
- zero  out  1  level, high when digits == 0
- step_pulse  out  1  one-cycle strobe on every decrement
- expired  out  1  one-cycle pulse on entry to DONE

## Operation
- States: IDLE, RUN, PAUSED, DONE. Reset leads to IDLE with digits = RESET_VALUE, prescaler = 0, running/step_pulse/expired = 0.
- Command priority per cycle: rst > load > add_en > pause > start > prescaler step.
- load, from any state: digits = load_value, prescaler = 0, state = IDLE. Any input digit >9 is clamped to 9.
- start:
  - From IDLE, with the value nonzero: go to RUN and clear the prescaler.
  - From PAUSED, with the value nonzero: go to RUN and keep the prescaler.
  - From IDLE or PAUSED, with the value zero: go to DONE and pulse expired.
  - Ignored in RUN and DONE.
- pause: in RUN, go to PAUSED and freeze the prescaler. Ignored elsewhere. pause and start together: pause wins.
- add_en, in IDLE/RUN/PAUSED: digits = BCD sum of digits and add_value with ripple carry across digits.
  - Each add_value digit >9 is clamped to 9.
  - Carry out of the top digit saturates the whole value to all 9s.
  - Ignored in DONE, so no revival after game over.
- Step: in RUN, the prescaler counts 0..CYCLES_PER_STEP-1 and wraps.
  - At terminal count, the BCD value decrements by one with borrow (e.g. 10 -> 09, 100 -> 099).
  - step_pulse is asserted.
  - If the result is 0, state = DONE and expired is asserted.
- add_en during the terminal-count cycle: the add is applied, the prescaler holds at terminal, and the decrement happens on the next cycle. No step is lost or merged.
- DONE: digits stay 0. Only load or rst leaves this state.
- Digits never underflow. A decrement is only issued when the value is nonzero.

## Timing
- All outputs are registered. Commands take effect on the edge where they are sampled. New digits, running and zero are visible the following cycle.
- First decrement occurs exactly CYCLES_PER_STEP cycles after the start edge from IDLE.
- step_pulse and expired are high for exactly one cycle. They are coincident with the first cycle that shows the new digits.
- Pause/resume preserves the partial prescaler count. Total elapsed RUN cycles per step is always CYCLES_PER_STEP.
- rst mid-count: the next cycle shows RESET_VALUE and IDLE, with no pulse.
- load concurrent with a terminal count: load wins and there is no step_pulse.

## Test plan
- NUM_DIGITS=2, CYCLES_PER_STEP=4, reset -> digits=0x60, IDLE. Then load 0x12, start -> step_pulse every 4 cycles, sequence 12,11,10,09…01,00. expired fires once with 00, running drops.
- Load 0x05, start, pause after 2 cycles, hold 10 cycles, start -> the next decrement to 04 occurs 2 RUN cycles after resume.
- Load 0x95, add 0x07 -> 0x99 (saturated). Load 0x38, add 0x0A (clamped to 09) -> 0x47.
- RUN at 0x03, add_en 0x10 on the terminal-count cycle -> 0x13 next cycle, 0x12 the cycle after, with a single step_pulse.
- Load 0x00, start -> DONE, expired pulse once. add_en and start are then ignored, digits stay 00. load 0x20 -> IDLE.
- NUM_DIGITS=3, load 0x100, start -> after one step 0x099. Assert rst mid-step -> digits = RESET_VALUE, IDLE, no pulses.

Source files
------------

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD count-down timer with start/pause control, saturating
// bonus-time addition, a step strobe per decrement and a one-cycle expiry pulse.
module bcd_countdown_timer #(
  parameter int                      NUM_DIGITS      = 2,
  parameter int                      CYCLES_PER_STEP = 50000000,
  parameter logic [4*NUM_DIGITS-1:0] RESET_VALUE     = 'h60
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    add_en,
  input  logic [4*NUM_DIGITS-1:0] add_value,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    running,
  output logic                    zero,
  output logic                    step_pulse,
  output logic                    expired
);

  localparam int W  = 4 * NUM_DIGITS;
  localparam int PW = $clog2(CYCLES_PER_STEP);

  localparam logic [PW-1:0] PRESC_LAST = PW'(CYCLES_PER_STEP - 1);
  localparam logic [W-1:0]  ALL_NINES  = {NUM_DIGITS{4'h9}};

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_PAUSED = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Force every nibble into the legal BCD range 0..9.
  function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  // Ripple-carry BCD add; a carry out of the top digit pins the value at all 9s.
  function automatic logic [W-1:0] bcd_add_sat(input logic [W-1:0] a,
                                               input logic [W-1:0] b);
    logic [W-1:0] r;
    logic [4:0]   s;
    logic         c;
    r = '0;
    c = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'd0, c};
      if (s > 5'd9) begin
        r[4*i +: 4] = 4'(s - 5'd10);
        c           = 1'b1;
      end else begin
        r[4*i +: 4] = s[3:0];
        c           = 1'b0;
      end
    end
    if (c) r = ALL_NINES;
    return r;
  endfunction

  // Subtract one with borrow propagating through zero digits (100 -> 099).
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] a);
    logic [W-1:0] r;
    logic         bw;
    r  = a;
    bw = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bw) begin
        if (a[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = a[4*i +: 4] - 4'd1;
          bw          = 1'b0;
        end
      end
    end
    return r;
  endfunction

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  digits_q, digits_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          step_q, step_d;
  logic          exp_q, exp_d;
  logic          running_q, running_d;
  logic          zero_q, zero_d;
  logic [W-1:0]  dec_val;
  logic          nonzero;

  // Next-state decode in command priority order: load > add > pause > start > step.
  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    presc_d  = presc_q;
    step_d   = 1'b0;
    exp_d    = 1'b0;
    dec_val  = bcd_dec(digits_q);
    nonzero  = (digits_q != '0);

    if (load) begin
      digits_d = bcd_clamp(load_value);
      presc_d  = '0;
      state_d  = ST_IDLE;
    end else if (add_en && (state_q != ST_DONE)) begin
      // Prescaler holds, so an add on the terminal cycle defers the step by one.
      digits_d = bcd_add_sat(digits_q, bcd_clamp(add_value));
    end else if (pause && (state_q == ST_RUN)) begin
      state_d = ST_PAUSED;
    end else if (start && ((state_q == ST_IDLE) || (state_q == ST_PAUSED))) begin
      if (nonzero) begin
        state_d = ST_RUN;
        if (state_q == ST_IDLE) presc_d = '0;
      end else begin
        state_d = ST_DONE;
        exp_d   = 1'b1;
      end
    end else if (state_q == ST_RUN) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        if (nonzero) begin
          digits_d = dec_val;
          step_d   = 1'b1;
          if (dec_val == '0) begin
            state_d = ST_DONE;
            exp_d   = 1'b1;
          end
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end

    running_d = (state_d == ST_RUN);
    zero_d    = (digits_d == '0);
  end

  // State, value, prescaler and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      digits_q  <= RESET_VALUE;
      presc_q   <= '0;
      step_q    <= 1'b0;
      exp_q     <= 1'b0;
      running_q <= 1'b0;
      zero_q    <= (RESET_VALUE == '0);
    end else begin
      state_q   <= state_d;
      digits_q  <= digits_d;
      presc_q   <= presc_d;
      step_q    <= step_d;
      exp_q     <= exp_d;
      running_q <= running_d;
      zero_q    <= zero_d;
    end
  end

  assign digits     = digits_q;
  assign running    = running_q;
  assign zero       = zero_q;
  assign step_pulse = step_q;
  assign expired    = exp_q;

endmodule
